// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer stage for the async FIFO.
// Turns the FIFO's rd_en / registered rd_dout / fifo_empty interface into a
// valid/ready stream. Words are prefetched into a 2-entry output buffer so a
// beat can be delivered every cycle while m_ready stays high.
//
// Optional statistics counters are built only when FIFO_RD_STREAM_STAT_EN is
// defined. Otherwise stat_beats and stat_stalls are tied to 0. The port list
// is the same in both builds.
//
// Stream handshake: a beat transfers on every clk edge where m_valid and
// m_ready are both high. m_valid never depends on m_ready. While m_valid is
// high and m_ready is low, m_valid and m_data hold stable.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [31:0]           stat_beats,
  output logic [31:0]           stat_stalls
);

  // The skid logic below is written for exactly two entries.
  generate
    if (BUF_DEPTH != 2) begin : g_bad_depth
      $error("fifo_rd_stream: BUF_DEPTH must be 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0]            cnt;      // words held in the buffer (0..2)
  logic                  head;     // index of the oldest word
  logic                  infl;     // a popped word arrives on fifo_rd_dout this cycle
  logic                  drop;     // the word arriving this cycle was flushed
  logic                  deq;
  logic                  cap;
  logic                  pop_acc;
  logic                  wr_idx;
  logic [1:0]            occ;

  assign deq     = m_valid & m_ready;
  assign cap     = infl & ~drop;
  // The tail slot is head+cnt mod 2. When the buffer is full, that is the head
  // slot, which is freed by the same-cycle dequeue.
  assign wr_idx  = head ^ cnt[0];
  // Buffer occupancy after this cycle, counting the word still in flight.
  // The issue rule keeps cnt+infl <= 2, so 2 bits are enough.
  assign occ     = cnt + {1'b0, infl} - {1'b0, deq};

  // Pop only when the word is sure to have a free slot on arrival.
  always_comb begin
    fifo_rd_en = ~rst & ~flush & ~fifo_empty & (occ < 2'd2);
  end

  assign pop_acc = fifo_rd_en & ~fifo_empty;

  // Buffer contents, occupancy, head pointer and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      head   <= 1'b0;
      infl   <= 1'b0;
      drop   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      // An arriving in-flight word is discarded. Words already popped are lost.
      cnt  <= 2'd0;
      head <= 1'b0;
      infl <= 1'b0;
      drop <= infl;
    end else begin
      infl <= pop_acc;
      drop <= 1'b0;
      if (cap) mem[wr_idx] <= fifo_rd_dout;
      if (deq) head <= ~head;
      cnt <= cnt + {1'b0, cap} - {1'b0, deq};
    end
  end

  assign m_valid = (cnt != 2'd0);
  assign m_data  = mem[head];

`ifdef FIFO_RD_STREAM_STAT_EN
  logic [31:0] beats_q;
  logic [31:0] stalls_q;

  // Saturating beat and stall counters. They are cleared by reset only, not by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (deq && beats_q != 32'hFFFF_FFFF) beats_q <= beats_q + 32'd1;
      if (m_valid && !m_ready && stalls_q != 32'hFFFF_FFFF) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_beats  = 32'd0;
  assign stat_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream. It includes a behavioural upstream FIFO with
// registered read data, table-driven stream and back-pressure vectors, and
// hand-written sequences for the full-buffer, flush and reset corner cases.
module tb_fifo_rd_stream;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [31:0]   stat_beats;
  logic [31:0]   stat_stalls;

  logic [DW-1:0] src_q[$];   // contents of the upstream FIFO
  logic [DW-1:0] exp_q[$];   // expected stream words
  logic          pop_pend;
  int            n_checks = 0;
  int            n_pass   = 0;

  typedef struct {
    logic          rdy;
    logic          en;
    logic          vld;
    logic [DW-1:0] dat;
  } vec_t;

  vec_t tbl[19];

  fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_dout (fifo_rd_dout),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .stat_beats   (stat_beats),
    .stat_stalls  (stat_stalls)
  );

  // Clock.
  always #5 clk = ~clk;

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // This task is called at the negedge, after the checks. It decides whether
  // the FIFO pops, crosses the posedge, and then updates the FIFO model
  // (registered read data).
  task automatic end_cycle();
    pop_pend = fifo_rd_en && !fifo_empty;
    @(posedge clk);
    #1;
    if (pop_pend) fifo_rd_dout = src_q.pop_front();
    fifo_empty = (src_q.size() == 0);
  endtask

  task automatic push4();
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    src_q.push_back(8'h44);
    fifo_empty = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      m_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("row%0d rd_en", i), {31'd0, fifo_rd_en}, {31'd0, tbl[i].en});
      check($sformatf("row%0d valid", i), {31'd0, m_valid}, {31'd0, tbl[i].vld});
      if (tbl[i].vld) check($sformatf("row%0d data", i), {24'd0, m_data}, {24'd0, tbl[i].dat});
      end_cycle();
    end
  endtask

  task automatic check_stats(input string tag, input logic [31:0] beats, input logic [31:0] stalls);
`ifdef FIFO_RD_STREAM_STAT_EN
    check({tag, " stat_beats"}, stat_beats, beats);
    check({tag, " stat_stalls"}, stat_stalls, stalls);
`else
    check({tag, " stat_beats"}, stat_beats, 32'd0);
    check({tag, " stat_stalls"}, stat_stalls, 32'd0);
    if (beats != stalls) begin end
`endif
  endtask

  initial begin
    // Stream: 0x11..0x44 with m_ready high throughout.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h11};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h22};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h33};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h44};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00};
    // Back-pressure: two pops, then 5 stall cycles holding 0x11, then drain.
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h11};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h11};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h11};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h11};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h11};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 8'h11};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 8'h22};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 8'h33};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 8'h44};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 8'h00};

    rst          = 1'b1;
    flush        = 1'b0;
    m_ready      = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_dout = '0;
    pop_pend     = 1'b0;

    // Reset for two cycles, then idle.
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("reset valid", {31'd0, m_valid}, 32'd0);
      check("reset data", {24'd0, m_data}, 32'd0);
      check("reset rd_en", {31'd0, fifo_rd_en}, 32'd0);
      if (c == 1) check_stats("reset", 32'd0, 32'd0);
      end_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("idle valid", {31'd0, m_valid}, 32'd0);
    end_cycle();

    // Stream test.
    push4();
    run_rows(0, 6);
    check_stats("stream", 32'd4, 32'd0);

    // Back-pressure test.
    push4();
    run_rows(7, 18);
    check_stats("backpressure", 32'd8, 32'd5);

    // Full buffer, then simultaneous enqueue and dequeue over 8 words.
    for (int w = 0; w < 8; w++) begin
      src_q.push_back(w[DW-1:0]);
      exp_q.push_back(w[DW-1:0]);
    end
    fifo_empty = 1'b0;
    m_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("fill%0d rd_en", c), {31'd0, fifo_rd_en}, {31'd0, (c < 2)});
      check($sformatf("fill%0d valid", c), {31'd0, m_valid}, {31'd0, (c >= 2)});
      end_cycle();
    end
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("full%0d valid", k), {31'd0, m_valid}, 32'd1);
      check($sformatf("full%0d data", k), {24'd0, m_data}, {24'd0, exp_q.pop_front()});
      check($sformatf("full%0d rd_en", k), {31'd0, fifo_rd_en}, {31'd0, (k < 6)});
      end_cycle();
    end
    @(negedge clk);
    check("full drained valid", {31'd0, m_valid}, 32'd0);
    end_cycle();

    // Flush while 0xAA is in flight; 0xBB follows normally.
    src_q.push_back(8'hAA);
    src_q.push_back(8'hBB);
    fifo_empty = 1'b0;
    @(negedge clk);
    check("flush pop AA rd_en", {31'd0, fifo_rd_en}, 32'd1);
    end_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush cycle rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("flush cycle valid", {31'd0, m_valid}, 32'd0);
    end_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("post flush valid1", {31'd0, m_valid}, 32'd0);
    check("post flush rd_en", {31'd0, fifo_rd_en}, 32'd1);
    end_cycle();
    @(negedge clk);
    check("post flush valid2", {31'd0, m_valid}, 32'd0);
    end_cycle();
    @(negedge clk);
    check("BB valid", {31'd0, m_valid}, 32'd1);
    check("BB data", {24'd0, m_data}, 32'h0000_00BB);
    end_cycle();
    @(negedge clk);
    check("after BB valid", {31'd0, m_valid}, 32'd0);
    end_cycle();

    // Mid-stream reset with the buffer full.
    src_q.push_back(8'h51);
    src_q.push_back(8'h52);
    src_q.push_back(8'h53);
    fifo_empty = 1'b0;
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      end_cycle();
    end
    @(negedge clk);
    check("pre-reset full valid", {31'd0, m_valid}, 32'd1);
    check("pre-reset full data", {24'd0, m_data}, 32'h0000_0051);
    end_cycle();
    rst = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("mid reset rd_en", {31'd0, fifo_rd_en}, 32'd0);
    end_cycle();
    @(negedge clk);
    check("after reset valid", {31'd0, m_valid}, 32'd0);
    check("after reset data", {24'd0, m_data}, 32'd0);
    check("after reset rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_stats("mid reset", 32'd0, 32'd0);
    end_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("restart rd_en", {31'd0, fifo_rd_en}, 32'd1);
    end_cycle();
    @(negedge clk);
    check("restart valid0", {31'd0, m_valid}, 32'd0);
    end_cycle();
    @(negedge clk);
    check("restart valid", {31'd0, m_valid}, 32'd1);
    check("restart data", {24'd0, m_data}, 32'h0000_0053);
    end_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
